// File: rtl/mem_burst_master.sv
// mem_burst_master: sequences burst reads/writes on the single-port word memory,
// fed by a write stream and draining into a registered read stream.
module mem_burst_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir,
  input  logic [15:0] base,
  input  logic [15:0] count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [1:0]  mem_mode,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);
  localparam logic [1:0] MODE_NOP = 2'b00;
  localparam logic [1:0] MODE_IN  = 2'b01;
  localparam logic [1:0] MODE_OUT = 2'b10;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD_REQ  = 3'd2;
  localparam logic [2:0] RD_CAP  = 3'd3;
  localparam logic [2:0] RD_HOLD = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  logic [2:0]  state_q, state_d;
  logic [15:0] addr_q, addr_d, rem_q, rem_d, rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d, adv;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (count == '0) ? DONE : dir ? WR : RD_REQ;
      WR:      if (abort || (wr_valid && rem_q == 16'd1)) state_d = DONE;
      RD_REQ:  state_d = abort ? DONE : RD_CAP;
      RD_CAP:  state_d = abort ? DONE : RD_HOLD;
      RD_HOLD: state_d = abort ? DONE : !rd_ready ? RD_HOLD : (rem_q != '0) ? RD_REQ : DONE;
      default: state_d = IDLE;
    endcase
  end
  // a word is consumed on an accepted write beat or a read capture
  always_comb begin
    adv        = !abort && ((state_q == WR && wr_valid) || state_q == RD_CAP);
    addr_d     = (state_q == IDLE && start) ? base : adv ? addr_q + 16'd1 : addr_q;
    rem_d      = (state_q == IDLE && start) ? count : adv ? rem_q - 16'd1 : rem_q;
    rd_data_d  = (state_q == RD_CAP && !abort) ? mem_rdata : rd_data_q;
    rd_valid_d = (state_d == RD_HOLD);
  end
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    wr_ready  = (state_q == WR) && !abort;
    mem_mode  = (state_q == WR && wr_valid && !abort) ? MODE_IN :
                (state_q == RD_REQ && !abort) ? MODE_OUT : MODE_NOP;
    mem_addr  = addr_q;
    mem_wdata = reset ? wr_data : '0;
    rd_data   = rd_data_q;
    rd_valid  = rd_valid_q;
  end
endmodule
